// File: rtl/simd_mc_stream_tx.sv
// Memory-controller-side transmitter: buffers opA/opB vectors and, on start, issues an
// instruction followed by a gap-free stream of operand pairs toward the SIMD top level.
module simd_mc_stream_tx #(
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 128,
  parameter int SETUP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data_opa,
  input  logic [DATA_W-1:0] wr_data_opb,
  input  logic              start,
  input  logic [2:0]        start_instruction,
  input  logic [5:0]        start_count,
  output logic              busy,
  output logic              done,
  output logic              valid_instruction,
  output logic [2:0]        instruction,
  output logic [5:0]        data_size,
  output logic              valid_data,
  output logic [DATA_W-1:0] mc_data_in_opa,
  output logic [DATA_W-1:0] mc_data_in_opb
);

  typedef enum logic [1:0] {IDLE, ARM, STREAM, DONE} state_t;

  localparam logic [3:0] ARM_LAST = 4'(SETUP_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [3:0]        arm_cnt_reg, arm_cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [2:0]        instr_reg, instr_next;
  logic [5:0]        count_reg, count_next;

  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       vinstr_reg, vinstr_next;
  logic [2:0] instruction_reg, instruction_next;
  logic [5:0] data_size_reg, data_size_next;
  logic       vdata_reg, vdata_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      arm_cnt_reg <= '0;
      addr_reg    <= '0;
      instr_reg   <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      arm_cnt_reg <= arm_cnt_next;
      addr_reg    <= addr_next;
      instr_reg   <= instr_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    arm_cnt_next = arm_cnt_reg;
    addr_next    = addr_reg;
    instr_next   = instr_reg;
    count_next   = count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = ARM;
          arm_cnt_next = '0;
          instr_next   = start_instruction;
          count_next   = start_count;
        end
      end
      ARM: begin
        if (arm_cnt_reg == ARM_LAST) begin
          state_next = STREAM;
          addr_next  = '0;
        end else begin
          arm_cnt_next = arm_cnt_reg + 4'd1;
        end
      end
      STREAM: begin
        // addr_reg is the entry on the outputs now; stop on the last one, never wrap
        if (addr_reg == ADDR_W'(count_reg)) begin
          state_next = DONE;
        end else begin
          addr_next = addr_reg + ADDR_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers line up with it
  always_comb begin
    busy_next        = (state_next != IDLE);
    vinstr_next      = (state_next == ARM) || (state_next == STREAM);
    instruction_next = vinstr_next ? instr_next : 3'd0;
    data_size_next   = vinstr_next ? count_next : 6'd0;
    vdata_next       = (state_next == STREAM);
    done_next        = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      vinstr_reg      <= 1'b0;
      instruction_reg <= '0;
      data_size_reg   <= '0;
      vdata_reg       <= 1'b0;
    end else begin
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      vinstr_reg      <= vinstr_next;
      instruction_reg <= instruction_next;
      data_size_reg   <= data_size_next;
      vdata_reg       <= vdata_next;
    end
  end

  logic wr_ok;
  assign wr_ok = wr_en && !busy_reg;

  // Bank 0 holds opA, bank 1 holds opB; the read register doubles as the output register
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_data_reg;

    assign wdata = (gi == 0) ? wr_data_opa : wr_data_opb;

    always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_addr] <= wdata;
    end

    always_ff @(posedge clk) begin
      if (reset)           rd_data_reg <= '0;
      else if (vdata_next) rd_data_reg <= mem[addr_next];
      else                 rd_data_reg <= '0;
    end
  end

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign valid_instruction = vinstr_reg;
  assign instruction       = instruction_reg;
  assign data_size         = data_size_reg;
  assign valid_data        = vdata_reg;
  assign mc_data_in_opa    = g_bank[0].rd_data_reg;
  assign mc_data_in_opb    = g_bank[1].rd_data_reg;

endmodule

// File: tb/tb_simd_mc_stream_tx.sv
// Bench for simd_mc_stream_tx: per-cycle comparison against a transfer-schedule model,
// directed scenarios with literal expectations, then a randomized phase.
module tb_simd_mc_stream_tx;
  localparam int S  = 2;
  localparam int DW = 128;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [DW-1:0] wr_data_opa, wr_data_opb;
  logic          start;
  logic [2:0]    start_instruction;
  logic [5:0]    start_count;
  logic          busy, done, valid_instruction, valid_data;
  logic [2:0]    instruction;
  logic [5:0]    data_size;
  logic [DW-1:0] mc_data_in_opa, mc_data_in_opb;

  simd_mc_stream_tx #(.DEPTH(64), .ADDR_W(6), .DATA_W(DW), .SETUP_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data_opa(wr_data_opa), .wr_data_opb(wr_data_opb),
    .start(start), .start_instruction(start_instruction), .start_count(start_count),
    .busy(busy), .done(done), .valid_instruction(valid_instruction),
    .instruction(instruction), .data_size(data_size), .valid_data(valid_data),
    .mc_data_in_opa(mc_data_in_opa), .mc_data_in_opb(mc_data_in_opb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: buffer image plus j = position within the current transfer (0 = idle, 1 = T+1, ...)
  logic [DW-1:0] m_opa [64];
  logic [DW-1:0] m_opb [64];
  int            j = 0;
  int            m_cnt = 0;
  logic [2:0]    m_instr = 3'd0;

  initial begin
    logic          e_busy, e_done, e_vi, e_vd;
    logic [2:0]    e_instr;
    logic [5:0]    e_ds;
    logic [DW-1:0] e_opa, e_opb;
    forever begin
      @(posedge clk);
      if (reset) begin
        j = 0;
      end else if (j == 0) begin
        if (wr_en) begin
          m_opa[wr_addr] = wr_data_opa;
          m_opb[wr_addr] = wr_data_opb;
        end
        if (start) begin
          j = 1;
          m_instr = start_instruction;
          m_cnt = int'(start_count);
        end
      end else if (j == S + m_cnt + 2) begin
        j = 0;
      end else begin
        j++;
      end
      #1;
      e_busy  = (j != 0);
      e_vi    = (j >= 1) && (j <= S + m_cnt + 1);
      e_vd    = (j > S) && (j <= S + m_cnt + 1);
      e_done  = (j == S + m_cnt + 2);
      e_instr = e_vi ? m_instr : 3'd0;
      e_ds    = e_vi ? 6'(m_cnt) : 6'd0;
      e_opa   = e_vd ? m_opa[j - S - 1] : '0;
      e_opb   = e_vd ? m_opb[j - S - 1] : '0;
      tests++;
      if (busy !== e_busy || done !== e_done || valid_instruction !== e_vi ||
          valid_data !== e_vd || instruction !== e_instr || data_size !== e_ds ||
          mc_data_in_opa !== e_opa || mc_data_in_opb !== e_opb) begin
        fails++;
        $display("FAIL cycle_model t=%0t got busy=%b done=%b vi=%b vd=%b ins=%0d ds=%0d a=%h b=%h required busy=%b done=%b vi=%b vd=%b ins=%0d ds=%0d a=%h b=%h",
                 $time, busy, done, valid_instruction, valid_data, instruction, data_size,
                 mc_data_in_opa, mc_data_in_opb, e_busy, e_done, e_vi, e_vd, e_instr, e_ds,
                 e_opa, e_opb);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] a, input logic [DW-1:0] b);
    wr_en = 1'b1; wr_addr = 6'(addr); wr_data_opa = a; wr_data_opb = b;
    tick();
    wr_en = 1'b0;
  endtask

  // Returns at the negedge inside cycle T+1
  task automatic go(input logic [2:0] ins, input int cnt);
    start = 1'b1; start_instruction = ins; start_count = 6'(cnt);
    tick();
    start = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] lit_a, lit_b, e13, ones, lit6;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data_opa = '0; wr_data_opb = '0;
    start = 1'b0; start_instruction = '0; start_count = '0;
    tick(3);
    chk("reset_busy", DW'(busy), '0);
    chk("reset_opa", mc_data_in_opa, '0);
    reset = 1'b0;
    tick();

    // 14-entry transfer, instr 101, count 13
    lit_a = 128'h11111111_22222222_55555555_66666666;
    lit_b = 128'h11111111_22222222_33333333_44444444;
    wr(0, lit_a, lit_b);
    for (int k = 1; k < 14; k++) wr(k, rnd128(), rnd128());
    e13 = m_opa[13];
    go(3'b101, 13);
    chk("t1_vi_T1", DW'(valid_instruction), DW'(1));
    chk("t1_vd_T1", DW'(valid_data), '0);
    tick();
    chk("t1_vd_T2", DW'(valid_data), '0);
    tick();
    chk("t1_vd_T3", DW'(valid_data), DW'(1));
    chk("t1_opa_T3", mc_data_in_opa, lit_a);
    chk("t1_opb_T3", mc_data_in_opb, lit_b);
    chk("t1_ds_T3", DW'(data_size), DW'(13));
    chk("t1_ins_T3", DW'(instruction), DW'(5));
    tick(13);
    chk("t1_vd_T16", DW'(valid_data), DW'(1));
    chk("t1_opa_T16", mc_data_in_opa, e13);
    tick();
    chk("t1_done_T17", DW'(done), DW'(1));
    chk("t1_vd_T17", DW'(valid_data), '0);
    tick();
    chk("t1_busy_T18", DW'(busy), '0);

    // Single-vector transfer
    ones = '1;
    wr(0, ones, rnd128());
    go(3'b010, 0);
    tick(2);
    chk("t2_vd_T3", DW'(valid_data), DW'(1));
    chk("t2_opa_T3", mc_data_in_opa, ones);
    tick();
    chk("t2_done_T4", DW'(done), DW'(1));
    chk("t2_vd_T4", DW'(valid_data), '0);
    tick(2);

    // Full 64-entry transfer, no wrap
    for (int k = 0; k < 64; k++) wr(k, {4{32'(k)}}, {4{32'(k)}});
    go(3'b011, 63);
    tick(2);
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("t3_opa_%0d", k), valid_data ? mc_data_in_opa : ~mc_data_in_opa, {4{32'(k)}});
      tick();
    end
    chk("t3_done", DW'(done), DW'(1));
    tick(2);

    // Start and write during STREAM are both ignored
    go(3'b110, 10);
    tick(3);
    start = 1'b1; start_count = 6'd0; start_instruction = 3'd7;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data_opa = '1; wr_data_opb = '1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    tick();
    chk("t4_no_restart_ds", DW'(data_size), DW'(10));
    tick(12);
    go(3'b001, 7);
    tick(7);
    chk("t4_entry5_opa", mc_data_in_opa, {4{32'd5}});
    chk("t4_entry5_opb", mc_data_in_opb, {4{32'd5}});
    tick(6);

    // Reset sampled at edge T+6 aborts the transfer
    go(3'b100, 20);
    tick(5);
    reset = 1'b1;
    tick();
    chk("t5_busy_T7", DW'(busy), '0);
    chk("t5_vd_T7", DW'(valid_data), '0);
    chk("t5_vi_T7", DW'(valid_instruction), '0);
    reset = 1'b0;
    tick(3);
    chk("t5_no_done", DW'(done), '0);
    go(3'b100, 3);
    tick(2);
    chk("t5_replay_vd", DW'(valid_data), DW'(1));
    tick();
    chk("t5_replay_e1", mc_data_in_opa, {4{32'd1}});
    tick(5);

    // Write and start in the same IDLE cycle
    lit6 = 128'h00000001_00000001_00000001_00000001;
    wr_en = 1'b1; wr_addr = 6'd0; wr_data_opa = lit6; wr_data_opb = rnd128();
    start = 1'b1; start_instruction = 3'b111; start_count = 6'd2;
    tick();
    wr_en = 1'b0; start = 1'b0;
    tick(2);
    chk("t6_same_cycle_opa", mc_data_in_opa, lit6);
    tick(4);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 1500; c++) begin
      wr_en = ($urandom_range(0, 9) < 3);
      wr_addr = 6'($urandom_range(0, 63));
      wr_data_opa = rnd128();
      wr_data_opb = rnd128();
      start = ($urandom_range(0, 19) < 3);
      start_instruction = 3'($urandom_range(0, 7));
      start_count = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    wr_en = 1'b0; start = 1'b0; reset = 1'b0;
    tick(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/simd_mc_stream_tx.md
Name: simd_mc_stream_tx

Overview:
- Memory-controller-side transmitter that feeds the SIMD top level through its operand/instruction input interface.
- Holds a local operand buffer for opA/opB, loaded through a simple write port.
- On a start command it issues the instruction, then streams data_size+1 operand pairs at one pair per cycle with valid_data asserted.
- Replaces bench-driven stimulus, so the SIMD datapath can be exercised from on-chip logic.

Parameters:
DEPTH, 64, number of operand-pair entries in the buffer
ADDR_W, 6, buffer address width; DEPTH = 2**ADDR_W
DATA_W, 128, width of each operand vector
SETUP_CYCLES, 2, cycles valid_instruction is held before the first valid_data; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  buffer write strobe
wr_addr  input  ADDR_W  buffer write address
wr_data_opa  input  DATA_W  opA vector to store
wr_data_opb  input  DATA_W  opB vector to store
start  input  1  request to begin a transfer
start_instruction  input  3  opcode to issue
start_count  input  6  vectors to send minus one
busy  output  1  high from accepted start through the done cycle
done  output  1  one-cycle completion pulse
valid_instruction  output  1  instruction/data_size valid toward SIMD
instruction  output  3  opcode to SIMD
data_size  output  6  vector count minus one to SIMD
valid_data  output  1  operand pair valid this cycle
mc_data_in_opa  output  DATA_W  opA vector to SIMD
mc_data_in_opb  output  DATA_W  opB vector to SIMD

Behaviour:
- All outputs are registered. Reset is synchronous and active-high.
- At reset every output is 0 and the FSM goes to IDLE. Buffer contents are not cleared by reset.
- Reset asserted mid-operation aborts the transfer. Outputs are 0 after the next edge, and no done pulse is produced.
- FSM states: IDLE -> ARM -> STREAM -> DONE -> IDLE.
- IDLE:
  - start=1 at edge T is accepted: start_instruction and start_count are latched and the FSM moves to ARM.
  - start is ignored in every other state.
- ARM, cycles T+1 .. T+SETUP_CYCLES:
  - busy=1, valid_instruction=1, instruction and data_size driven from the latched values, valid_data=0.
- STREAM, cycles T+SETUP_CYCLES+1 .. T+SETUP_CYCLES+N, where N = latched count + 1:
  - valid_data=1.
  - Cycle k (k=0..N-1) presents buffer entry k on mc_data_in_opa/opb; addressing always starts at 0.
  - valid_instruction, instruction and data_size are held.
  - Buffer read latency is hidden by prefetch during ARM, so data is aligned with valid_data with no gaps.
- DONE, cycle T+SETUP_CYCLES+N+1:
  - done=1, busy=1, valid_data=0, valid_instruction=0. Next state is IDLE.
  - A start in this cycle is ignored.
  - A start in the following IDLE cycle is accepted.
- Outside STREAM, mc_data_in_opa/opb read 0. instruction and data_size read 0 whenever valid_instruction=0.
- Writes:
  - Accepted only when busy=0; wr_en while busy is dropped.
  - A write and a start in the same IDLE cycle: the write is committed and is visible to the stream.
- Boundaries:
  - start_count=0 sends exactly one vector (entry 0).
  - start_count=63 sends all 64 entries. The address counter stops at N-1 and never wraps within a transfer.

Test Plan:
- Load 14 entries, with entry0 opA=128'h11111111_22222222_55555555_66666666 and opB=128'h11111111_22222222_33333333_44444444. Start with instr=3'b101, count=13 at edge T -> valid_instruction high T+1..T+16; valid_data high exactly T+3..T+16; data_size=13; entry0 at T+3, entry13 at T+16; done at T+17; busy low at T+18.
- count=0, entry0 opA=128'hffffffff_ffffffff_ffffffff_ffffffff -> a single valid_data cycle at T+3 carrying that value; done at T+4.
- count=63 with entry k = {4{k as 32-bit}} -> 64 consecutive valid_data cycles carrying values 0..63 in order; no wrap, no gap.
- Start pulsed during STREAM and wr_en to entry 5 during STREAM -> no restart; entry 5 unchanged when a subsequent transfer reads it.
- Reset asserted at T+6 mid-stream -> all outputs 0 from T+7; no done pulse. A new start then replays from entry 0 with the buffer contents intact.
- Same-cycle wr_en to entry 0 (opA=128'h00000001_00000001_00000001_00000001) and start -> first streamed opA equals the newly written value.
